ram_checker: RTL and testbench

Read-back counterpart of `ram_filler`. On a start pulse it reads every RAM word at addresses 0 .. 2^ADDR_W-1 through the RAM controller read port and compares each returned word against the incremental or decremental test pattern. It reports mismatches as an error count plus the first failing address and data. It sits beside `ram_filler` on the RAM controller's test path and closes the fill-then-verify loop.

---
 rtl/ram_test_pkg.sv | 22 ++
 rtl/ram_checker.sv | 104 ++++++++++
 tb/tb_ram_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM fill/verify test path (ram_filler and ram_checker).
package ram_test_pkg;

  typedef enum logic {
    PAT_INC,
    PAT_DEC
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Result is 32 bits; callers truncate or zero-extend to their own data width.
  function automatic logic [31:0] pat_data(pattern_t pattern, logic [31:0] a, int unsigned addr_w);
    if (pattern == PAT_INC) return a;
    return (32'd1 << addr_w) - 32'd1 - a;
  endfunction

endpackage

// File: rtl/ram_checker.sv
// Reads back every RAM word after a start pulse and compares it against the INC/DEC
// test pattern, reporting the mismatch count and the first failing address/data.
module ram_checker
  import ram_test_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              check_inc,
  input  logic              check_dec,
  output logic              check_active,
  output logic              check_done,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_first_addr,
  output logic [DATA_W-1:0] err_first_data,
  output logic [ADDR_W-1:0] addr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid
);

  localparam logic [ADDR_W:0] TOTAL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  pattern_t          pattern;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   resp_cnt;
  logic [ADDR_W:0]   resp_next;
  logic [DATA_W-1:0] exp_word;
  logic              resp_take;

  assign exp_word  = DATA_W'(pat_data(pattern, 32'(resp_cnt), ADDR_W));
  assign resp_take = (state != ST_IDLE) && rvalid && (resp_cnt != TOTAL);
  assign resp_next = resp_cnt + (ADDR_W + 1)'(resp_take);

  // Issue side and response side advance independently; responses may overlap issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pattern        <= PAT_INC;
      issue_cnt      <= '0;
      resp_cnt       <= '0;
      check_active   <= 1'b0;
      check_done     <= 1'b0;
      err_cnt        <= '0;
      err_first_addr <= '0;
      err_first_data <= '0;
      addr           <= '0;
      ren            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (check_inc || check_dec) begin
            pattern        <= check_inc ? PAT_INC : PAT_DEC;
            err_cnt        <= '0;
            err_first_addr <= '0;
            err_first_data <= '0;
            resp_cnt       <= '0;
            issue_cnt      <= (ADDR_W + 1)'(1);
            addr           <= '0;
            ren            <= 1'b1;
            check_active   <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_cnt == TOTAL) begin
            ren   <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            addr      <= issue_cnt[ADDR_W-1:0];
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (resp_next == TOTAL) begin
            check_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          check_done   <= 1'b0;
          check_active <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (resp_take) begin
        resp_cnt <= resp_next;
        if (rdata != exp_word) begin
          err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) begin
            err_first_addr <= resp_cnt[ADDR_W-1:0];
            err_first_data <= rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_checker.sv
// Self-checking bench for ram_checker: behavioural RAM with programmable latency and a
// reference model that recomputes the expected error report from the RAM contents.
module tb_ram_checker;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int WORDS  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              check_inc = 1'b0;
  logic              check_dec = 1'b0;
  logic              check_active;
  logic              check_done;
  logic [ADDR_W:0]   err_cnt;
  logic [ADDR_W-1:0] err_first_addr;
  logic [DATA_W-1:0] err_first_data;
  logic [ADDR_W-1:0] addr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  logic stray_v = 1'b0;

  logic [DATA_W-1:0] mem [0:WORDS-1];
  logic              pipe_v [0:7];
  logic [DATA_W-1:0] pipe_d [0:7];

  ram_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .check_inc(check_inc), .check_dec(check_dec),
    .check_active(check_active), .check_done(check_done), .err_cnt(err_cnt),
    .err_first_addr(err_first_addr), .err_first_data(err_first_data),
    .addr(addr), .ren(ren), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  // RAM keeps returning in-flight reads regardless of the checker's reset.
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    pipe_v[0] <= ren;
    pipe_d[0] <= mem[addr];
  end

  assign rvalid = pipe_v[lat-1] | stray_v;
  assign rdata  = stray_v ? 16'hDEAD : pipe_d[lat-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic preload(input bit inc);
    for (int a = 0; a < WORDS; a++) mem[a] = inc ? 16'(a) : 16'(WORDS - 1 - a);
  endtask

  task automatic modelResult(input bit inc, output int cnt, output int fa, output int fd);
    cnt = 0; fa = 0; fd = 0;
    for (int a = 0; a < WORDS; a++) begin
      int want;
      want = inc ? a : WORDS - 1 - a;
      if (int'(mem[a]) != want) begin
        if (cnt == 0) begin
          fa = a;
          fd = int'(mem[a]);
        end
        cnt++;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_active"}, 32'(check_active), 0);
    checkOutput({tag, "_done"}, 32'(check_done), 0);
    checkOutput({tag, "_ren"}, 32'(ren), 0);
    checkOutput({tag, "_addr"}, 32'(addr), 0);
    checkOutput({tag, "_errcnt"}, 32'(err_cnt), 0);
    checkOutput({tag, "_faddr"}, 32'(err_first_addr), 0);
    checkOutput({tag, "_fdata"}, 32'(err_first_data), 0);
  endtask

  task automatic applyStimulus(input logic inc, input logic dec, input int mid_dec_at,
                               input int rst_at, output int k_done, output int ren_cnt,
                               output int addr_bad);
    @(negedge clk);
    check_inc = inc;
    check_dec = dec;
    k_done = -1; ren_cnt = 0; addr_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      check_inc = 1'b0;
      check_dec = (k == mid_dec_at);
      if (k == 1) checkOutput("active_after_start", 32'(check_active), 1);
      if (ren) begin
        if (addr != 3'(ren_cnt)) addr_bad++;
        ren_cnt++;
      end
      if (rst_at != 0 && ren_cnt == rst_at) begin
        rst_n = 1'b0;
        #1;
        checkReset("midrun_reset");
        k_done = 0;
        break;
      end
      if (check_done) begin
        k_done = k;
        break;
      end
    end
    check_dec = 1'b0;
  endtask

  task automatic runAndCheck(input logic inc, input logic dec, input bit exp_inc,
                             input int mid_dec_at, input string tag);
    int k_done, ren_cnt, addr_bad, cnt, fa, fd;
    modelResult(exp_inc, cnt, fa, fd);
    applyStimulus(inc, dec, mid_dec_at, 0, k_done, ren_cnt, addr_bad);
    checkOutput({tag, "_done_cycle"}, 32'(k_done), 32'(WORDS + lat + 1));
    checkOutput({tag, "_ren_cnt"}, 32'(ren_cnt), 32'(WORDS));
    checkOutput({tag, "_addr_seq"}, 32'(addr_bad), 0);
    checkOutput({tag, "_errcnt"}, 32'(err_cnt), 32'(cnt));
    checkOutput({tag, "_faddr"}, 32'(err_first_addr), 32'(fa));
    checkOutput({tag, "_fdata"}, 32'(err_first_data), 32'(fd));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(check_done), 0);
    checkOutput({tag, "_active_fall"}, 32'(check_active), 0);
    checkOutput({tag, "_errcnt_hold"}, 32'(err_cnt), 32'(cnt));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int k_done, ren_cnt, addr_bad;
    #1;
    checkReset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    lat = 1; preload(1);
    runAndCheck(1'b1, 1'b0, 1'b1, 0, "inc_ok");

    preload(0);
    runAndCheck(1'b1, 1'b0, 1'b1, 0, "inc_on_dec");

    lat = 3; preload(0); mem[5] = 16'hBEEF;
    runAndCheck(1'b0, 1'b1, 1'b0, 0, "dec_corrupt");

    lat = 1; preload(1);
    runAndCheck(1'b1, 1'b1, 1'b1, 3, "both_start");

    lat = 3; preload(0);
    applyStimulus(1'b1, 1'b0, 0, 4, k_done, ren_cnt, addr_bad);
    checkOutput("reset_addr_seq", 32'(addr_bad), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_v = 1'b1;
    repeat (2) @(negedge clk);
    stray_v = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("stray_errcnt", 32'(err_cnt), 0);
    checkOutput("stray_active", 32'(check_active), 0);
    lat = 1; preload(1);
    runAndCheck(1'b1, 1'b0, 1'b1, 0, "after_reset");

    for (int r = 0; r < 8; r++) begin
      bit pinc;
      lat = int'($urandom_range(1, 4));
      pinc = 1'($urandom_range(0, 1));
      preload(pinc);
      for (int a = 0; a < WORDS; a++)
        if ($urandom_range(0, 3) == 0) mem[a] = 16'($urandom);
      runAndCheck(pinc, !pinc, pinc, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
